// File: rtl/xlnx_rst_sequencer.sv
// Power-on reset sequencer: waits for a stable clock lock, pulses the DRAM controller reset, waits for calibration,
// then releases the SoC. All outputs are registered and change one cycle after the causing input; no backpressure.
module xlnx_rst_sequencer #(
  parameter int unsigned LockStableCycles = 16,
  parameter int unsigned DramRstCycles    = 32,
  parameter int unsigned CalibTimeout     = 2**20,
  parameter int unsigned SocRstHoldCycles = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clk_locked_i,
  input  logic       dram_calib_done_i,
  input  logic       sw_rst_req_i,
  input  logic [1:0] boot_mode_i,
  output logic       dram_rst_o,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       calib_err_o,
  output logic [2:0] state_o
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCycles =
    max2(max2(LockStableCycles, DramRstCycles), max2(CalibTimeout, SocRstHoldCycles));
  localparam int CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] LockLast  = CntW'(LockStableCycles - 1);
  localparam logic [CntW-1:0] DramLast  = CntW'(DramRstCycles - 1);
  localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeout - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(SocRstHoldCycles - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_DRAM_RST   = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_SOC_HOLD   = 3'd3,
    ST_RUN        = 3'd4,
    ST_ERROR      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sw_q;
  logic            sw_edge;
  logic [1:0]      boot_d;
  logic            dram_rst_d;
  logic            soc_rst_n_d;
  logic            calib_err_d;

  assign sw_edge = sw_rst_req_i & ~sw_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    boot_d  = boot_mode_o;

    // Losing lock anywhere past WAIT_LOCK restarts the whole sequence.
    if (state_q != ST_WAIT_LOCK && !clk_locked_i) begin
      state_d = ST_WAIT_LOCK;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (!clk_locked_i) begin
            cnt_d = '0;
          end else if (cnt_q == LockLast) begin
            state_d = ST_DRAM_RST;
          end
        end
        ST_DRAM_RST: begin
          if (cnt_q == DramLast) begin
            state_d = ST_WAIT_CALIB;
          end
        end
        ST_WAIT_CALIB: begin
          if (dram_calib_done_i) begin
            state_d = ST_SOC_HOLD;
          end else if (cnt_q == CalibLast) begin
            state_d = ST_ERROR;
          end
        end
        ST_SOC_HOLD: begin
          if (cnt_q == HoldLast) begin
            state_d = ST_RUN;
            boot_d  = boot_mode_i;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
          if (!dram_calib_done_i) begin
            state_d = ST_DRAM_RST;
          end else if (sw_edge) begin
            state_d = ST_SOC_HOLD;
          end
        end
        ST_ERROR: begin
          cnt_d = '0;
          if (sw_edge) begin
            state_d = ST_DRAM_RST;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
        end
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    dram_rst_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_DRAM_RST);
    soc_rst_n_d = (state_d == ST_RUN);
    calib_err_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      sw_q        <= 1'b0;
      dram_rst_o  <= 1'b1;
      soc_rst_no  <= 1'b0;
      boot_mode_o <= 2'd0;
      calib_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sw_q        <= sw_rst_req_i;
      dram_rst_o  <= dram_rst_d;
      soc_rst_no  <= soc_rst_n_d;
      boot_mode_o <= boot_d;
      calib_err_o <= calib_err_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_xlnx_rst_sequencer.sv
// Directed bench for xlnx_rst_sequencer; expected values are queued as each step is driven and popped when observed.
module tb_xlnx_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       calib;
  logic       sw;
  logic [1:0] boot_in;
  logic       dram_rst;
  logic       soc_rst_n;
  logic [1:0] boot_out;
  logic       calib_err;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  xlnx_rst_sequencer #(
    .LockStableCycles(4),
    .DramRstCycles   (8),
    .CalibTimeout    (100),
    .SocRstHoldCycles(16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clk_locked_i     (locked),
    .dram_calib_done_i(calib),
    .sw_rst_req_i     (sw),
    .boot_mode_i      (boot_in),
    .dram_rst_o       (dram_rst),
    .soc_rst_no       (soc_rst_n),
    .boot_mode_o      (boot_out),
    .calib_err_o      (calib_err),
    .state_o          (state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_out(input logic d, input logic s, input logic [1:0] b,
                                          input logic e, input logic [2:0] st);
    return {24'd0, d, s, b, e, st};
  endfunction

  function automatic logic [31:0] outs();
    return {24'd0, dram_rst, soc_rst_n, boot_out, calib_err, state};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // sel 0: dram_rst==val, sel 1: soc_rst_n==val, otherwise: state!=val
  function automatic bit cond(input int sel, input int val);
    case (sel)
      0:       return dram_rst === val[0];
      1:       return soc_rst_n === val[0];
      default: return state !== val[2:0];
    endcase
  endfunction

  task automatic wait_while(input int sel, input int val, output int n);
    n = 0;
    while (cond(sel, val) && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int   n;
    int   lows;
    logic dram_seen;

    rst_n = 1'b1; locked = 1'b0; calib = 1'b0; sw = 1'b0; boot_in = 2'd2;
    #1 rst_n = 1'b0;
    #3;
    push("reset_outs", exp_out(1, 0, 0, 0, 0)); check(outs());
    repeat (2) @(negedge clk);

    // Nominal bring-up
    locked = 1'b1; rst_n = 1'b1;
    push("nom_dram_high_cycles", 32'd12); wait_while(0, 1, n); check(32'(n));
    push("nom_wait_calib", exp_out(0, 0, 0, 0, 2)); check(outs());
    repeat (20) @(negedge clk);
    calib = 1'b1;
    @(negedge clk);
    push("nom_soc_hold", exp_out(0, 0, 0, 0, 3)); check(outs());
    push("nom_soc_low_cycles", 32'd16); wait_while(1, 0, n); check(32'(n));
    push("nom_run", exp_out(0, 1, 2, 0, 4)); check(outs());

    // Software reset held for 50 cycles
    boot_in = 2'd1; sw = 1'b1;
    @(negedge clk);
    push("sw_soc_hold", exp_out(0, 0, 2, 0, 3)); check(outs());
    dram_seen = 1'b0; n = 0;
    while (soc_rst_n === 1'b0 && n < 2000) begin
      dram_seen = dram_seen | dram_rst;
      @(negedge clk);
      n++;
    end
    push("sw_soc_low_cycles", 32'd16); check(32'(n));
    push("sw_dram_stays_low", 32'd0); check({31'd0, dram_seen});
    lows = 0;
    repeat (33) begin
      @(negedge clk);
      if (soc_rst_n !== 1'b1) lows++;
    end
    push("sw_held_single_action", 32'd0); check(32'(lows));
    push("sw_run_relatch", exp_out(0, 1, 1, 0, 4)); check(outs());
    sw = 1'b0;
    @(negedge clk);

    // Lock loss and sw edge in the same RUN cycle
    locked = 1'b0; sw = 1'b1;
    @(negedge clk);
    push("lockloss_sw_same", exp_out(1, 0, 1, 0, 0)); check(outs());
    sw = 1'b0;

    // Lock glitch: 3 high, 1 low, then needs 4 more
    locked = 1'b1;
    repeat (3) @(negedge clk);
    push("glitch_still_wait", exp_out(1, 0, 1, 0, 0)); check(outs());
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    push("glitch_relock_cycles", 32'd4); wait_while(2, 1, n); check(32'(n));

    // Calibration already done: DRAM_RST then straight into SOC_HOLD
    push("dram_then_calib_cycles", 32'd9); wait_while(2, 3, n); check(32'(n));
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    push("async_rst", exp_out(1, 0, 0, 0, 0)); check(outs());
    repeat (2) @(negedge clk);

    // Restart with calibration never completing
    calib = 1'b0; locked = 1'b1; rst_n = 1'b1;
    push("restart_to_calib", 32'd12); wait_while(2, 2, n); check(32'(n));
    push("timeout_cycles", 32'd100); wait_while(2, 5, n); check(32'(n));
    push("error_outs", exp_out(0, 0, 0, 1, 5)); check(outs());
    repeat (10) @(negedge clk);
    push("error_held", exp_out(0, 0, 0, 1, 5)); check(outs());
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    push("retry_dram", exp_out(1, 0, 0, 0, 1)); check(outs());
    push("retry_dram_cycles", 32'd8); wait_while(0, 1, n); check(32'(n));

    // calib_done arrives in the same cycle the timeout would fire
    boot_in = 2'd3;
    repeat (99) @(negedge clk);
    calib = 1'b1;
    @(negedge clk);
    push("calib_vs_timeout", exp_out(0, 0, 0, 0, 3)); check(outs());

    // sw request during SOC_HOLD must not restart the hold count
    repeat (5) @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    push("sw_ignored_hold_cycles", 32'd10); wait_while(1, 0, n); check(32'(n));
    push("run_boot3", exp_out(0, 1, 3, 0, 4)); check(outs());

    // Calibration loss in RUN
    calib = 1'b0;
    @(negedge clk);
    push("calib_loss", exp_out(1, 0, 3, 0, 1)); check(outs());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xlnx_rst_sequencer.md
XLNX_RST_SEQUENCER -- requirements
Module: xlnx_rst_sequencer

Interface
REQ-001 Parameter LockStableCycles, default 16: consecutive clk_locked_i high cycles required before leaving WAIT_LOCK; legal range >=1.
REQ-002 Parameter DramRstCycles, default 32: dram_rst_o pulse length in cycles; >=1.
REQ-003 Parameter CalibTimeout, default 2**20: maximum WAIT_CALIB cycles before ERROR; >=2.
REQ-004 Parameter SocRstHoldCycles, default 64: soc_rst_no low-hold in cycles after calibration or software reset; >=1.
REQ-005 clk_i  input  1  SoC clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 clk_locked_i  input  1  clock-wizard locked; level, synchronous to clk_i.
REQ-008 dram_calib_done_i  input  1  DRAM controller calibration complete; level, synchronous.
REQ-009 sw_rst_req_i  input  1  software/VIO reset request; level, acted on at rising edge only.
REQ-010 boot_mode_i  input  2  board/VIO boot mode selection.
REQ-011 dram_rst_o  output  1  active-high DRAM controller reset.
REQ-012 soc_rst_no  output  1  active-low SoC reset.
REQ-013 boot_mode_o  output  2  boot mode latched for the SoC.
REQ-014 calib_err_o  output  1  high while in ERROR.
REQ-015 state_o  output  3  current state encoding, for ILA/VIO observation.

Function
REQ-016 States and state_o encoding: WAIT_LOCK=0, DRAM_RST=1, WAIT_CALIB=2, SOC_HOLD=3, RUN=4, ERROR=5; values 6-7 unreachable, recover to WAIT_LOCK.
REQ-017 All outputs registered; output values depend only on the current state and latched boot mode.
REQ-018 dram_rst_o=1 in WAIT_LOCK and DRAM_RST, 0 otherwise.
REQ-019 soc_rst_no=1 only in RUN, 0 otherwise.
REQ-020 One shared cycle counter, width $clog2 of the largest parameter plus 1, cleared on every state transition.
REQ-021 WAIT_LOCK: counter increments while clk_locked_i=1, clears when clk_locked_i=0; transition to DRAM_RST in the cycle the counter equals LockStableCycles-1 with clk_locked_i=1.
REQ-022 DRAM_RST: transition to WAIT_CALIB when the counter equals DramRstCycles-1; dram_rst_o high for exactly DramRstCycles cycles.
REQ-023 WAIT_CALIB: dram_calib_done_i=1 -> SOC_HOLD; else counter equals CalibTimeout-1 -> ERROR; calib_done wins when both occur in the same cycle.
REQ-024 SOC_HOLD: transition to RUN when the counter equals SocRstHoldCycles-1; boot_mode_o captured from boot_mode_i on that transition cycle.
REQ-025 RUN: sw_rst_req_i rising edge -> SOC_HOLD (DRAM kept out of reset); dram_calib_done_i=0 -> DRAM_RST.
REQ-026 ERROR: sw_rst_req_i rising edge -> DRAM_RST (calibration retry); otherwise the state is held indefinitely.
REQ-027 clk_locked_i=0 in any state other than WAIT_LOCK -> WAIT_LOCK in the next cycle; this has highest priority over every other transition condition.
REQ-028 In RUN, priority is lock loss > calib loss > sw_rst_req_i edge.
REQ-029 Rising-edge detection uses a registered copy of sw_rst_req_i; a request held high causes one action only.
REQ-030 sw_rst_req_i in WAIT_LOCK, DRAM_RST, WAIT_CALIB and SOC_HOLD is ignored; the SOC_HOLD counter is not restarted.

Reset
REQ-031 While rst_ni=0: state=WAIT_LOCK, counter=0, dram_rst_o=1, soc_rst_no=0, boot_mode_o=0, calib_err_o=0, state_o=0, edge register=0.
REQ-032 Reset assertion mid-operation forces the REQ-031 values asynchronously, without waiting for a clock edge.
REQ-033 After rst_ni deassertion, the full sequence restarts from WAIT_LOCK.

Verification
Parameters for all scenarios: LockStableCycles=4, DramRstCycles=8, CalibTimeout=100, SocRstHoldCycles=16.
REQ-034 Nominal: locked=1 from reset release, calib_done rises 20 cycles after dram_rst_o falls, boot_mode_i=2 -> dram_rst_o high 4+8 cycles, soc_rst_no rises 16 cycles after calib_done is sampled, boot_mode_o=2.
REQ-035 Lock glitch: locked=1 for 3 cycles, then 0 for 1 cycle, then 1 -> DRAM_RST entered only after 4 further consecutive high cycles; lock drop in RUN -> soc_rst_no=0 and dram_rst_o=1 next cycle.
REQ-036 Calibration timeout: calib_done never rises -> ERROR after exactly 100 WAIT_CALIB cycles, calib_err_o=1, soc_rst_no=0; sw_rst_req_i pulse -> dram_rst_o high for 8 cycles, calib_err_o=0.
REQ-037 Software reset in RUN: sw_rst_req_i held high for 50 cycles -> soc_rst_no low for exactly 16 cycles once, dram_rst_o stays 0, boot_mode_o re-latched.
REQ-038 Simultaneous events: lock loss and sw_rst_req_i edge in the same RUN cycle -> WAIT_LOCK; calib_done and timeout in the same cycle -> SOC_HOLD.
REQ-039 Async reset mid-SOC_HOLD: rst_ni pulsed low between clock edges -> outputs reach REQ-031 values immediately, state_o=0.
